delay_response_scheduler: RTL and testbench
===========================================

DELAY_RESPONSE_SCHEDULER -- requirements
Module: delay_response_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending-request slots (2..16).
REQ-002 SHALL have parameter DLY_W, default 8, meaning the width of the per-request delay field.
REQ-003 SHALL have parameter TAG_W, default 4, meaning the width of the requester tag.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  requester presents a request.
REQ-007 SHALL have port req_delay  input  DLY_W  requested response delay N, in cycles.
REQ-008 SHALL have port req_tag  input  TAG_W  requester tag, returned with the response.
REQ-009 SHALL have port req_ready  output  1  at least one slot is free; combinational from slot state only.
REQ-010 SHALL have port req_err  output  1  registered one-cycle pulse when a request with N=0 is presented.
REQ-011 SHALL have port rsp_valid  output  1  registered one-cycle response pulse; no backpressure.
REQ-012 SHALL have port rsp_tag  output  TAG_W  tag of the slot being issued; 0 when rsp_valid=0.
REQ-013 SHALL have port rsp_late  output  1  the issued response is past its deadline; 0 when rsp_valid=0.
REQ-014 SHALL have port pending_cnt  output  clog2(DEPTH+1)  number of occupied slots.

Function
REQ-015 Accept SHALL occur on an edge where req_valid=1, req_ready=1 and req_delay!=0.
REQ-016 On accept, the block SHALL load the lowest-index free slot with tag, down-counter=N and state WAIT.
REQ-017 When req_valid=1, req_ready=1 and req_delay=0, the block SHALL load no slot and SHALL assert req_err in the following cycle.
REQ-018 When req_valid=1 and req_ready=0, the block SHALL ignore the request, leave state unchanged and keep req_err=0.
REQ-019 Slot states SHALL be FREE -> WAIT (on accept) -> READY (when the counter reaches 0) -> FREE (on the edge ending its rsp cycle).
REQ-020 A WAIT slot SHALL decrement its counter by 1 per cycle; the counter SHALL saturate at 0 and SHALL never wrap.
REQ-021 Uncontended, rsp_valid SHALL be high during the cycle that begins exactly N edges after the accepting edge.
REQ-022 The output arbiter SHALL issue at most one READY slot per cycle, choosing the lowest index, and the remaining READY slots SHALL stay READY.
REQ-023 rsp_late SHALL be 1 exactly when the issued slot reached its deadline at least one cycle before issue.
REQ-024 A slot freed by issue SHALL first be allocatable one cycle after its rsp cycle; req_ready SHALL NOT anticipate the free.
REQ-025 When accept and issue occur on the same edge, pending_cnt SHALL stay unchanged.
REQ-026 Otherwise pending_cnt SHALL increment by 1 on an accept and decrement by 1 on an issue.
REQ-027 With all DEPTH slots occupied, req_ready SHALL be 0.
REQ-028 N=2^DLY_W-1 SHALL be supported without overflow.

Reset
REQ-029 While rst=1 at an edge, every slot SHALL become FREE with counter 0 and tag 0.
REQ-030 After a reset edge, rsp_valid, rsp_tag, rsp_late, req_err and pending_cnt SHALL be 0.
REQ-031 req_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all pending requests, and no response for any of them SHALL be issued after reset.

Verification
REQ-033 Single request: accept N=2 at edge t, tag=5 -> rsp_valid=1, rsp_tag=5, rsp_late=0 only in the cycle after edge t+2; pending_cnt goes 1 then 0.
REQ-034 Collision: accept tag=1 N=3 at edge t and tag=2 N=2 at edge t+1 (slots 0 and 1) -> at cycle t+3 tag=1 is issued with late=0; at cycle t+4 tag=2 is issued with late=1.
REQ-035 Full: accept 4 requests with N=10 on consecutive edges -> req_ready=0 and pending_cnt=4; a 5th req_valid is ignored; req_ready returns to 1 the cycle after the first rsp.
REQ-036 Zero delay: req_delay=0 with req_valid=1 -> one-cycle req_err pulse, pending_cnt stays 0, and no rsp is issued.
REQ-037 Reset mid-flight: accept N=5, assert rst for one edge 2 cycles later -> no rsp ever appears, and all outputs are 0 with req_ready=1 after reset.
REQ-038 Max delay: accept N=255 (DLY_W=8) -> rsp exactly 255 edges after accept with late=0.

Source files
------------

// File: rtl/delay_response_scheduler.sv
// Delay-response scheduler: holds up to DEPTH tagged requests, each counting down its
// own delay, and issues one response per cycle (lowest slot first) with a late flag.
//
// slot state | meaning
// SLOT_FREE  | empty, allocatable
// SLOT_WAIT  | counter running toward its deadline
// SLOT_READY | deadline reached, waiting for the output arbiter
// SLOT_ISSUE | response on the output this cycle; frees at the next edge
module delay_response_scheduler #(
    parameter int DEPTH = 4,
    parameter int DLY_W = 8,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [DLY_W-1:0]             req_delay,
    input  logic [TAG_W-1:0]             req_tag,
    output logic                         req_ready,
    output logic                         req_err,
    output logic                         rsp_valid,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic                         rsp_late,
    output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_WAIT  = 2'd1,
        SLOT_READY = 2'd2,
        SLOT_ISSUE = 2'd3
    } slot_state_t;

    slot_state_t        r_state [DEPTH];
    logic [DLY_W-1:0]   r_cnt   [DEPTH];
    logic [TAG_W-1:0]   r_tag   [DEPTH];
    logic               r_rsp_valid;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_late;
    logic               r_req_err;

    slot_state_t        w_state_nxt [DEPTH];
    logic [DLY_W-1:0]   w_cnt_nxt   [DEPTH];
    logic [TAG_W-1:0]   w_tag_nxt   [DEPTH];
    logic               w_any_free;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic               w_iss_any;
    logic [IDX_W-1:0]   w_iss_idx;
    logic [TAG_W-1:0]   w_iss_tag;
    logic               w_iss_late;
    logic [CNT_W-1:0]   w_busy;
    logic               w_accept;
    logic               w_zero_dly;

    // A WAIT slot whose counter is 1 hits its deadline on this edge and may be issued
    // on time; descending scan leaves the lowest index selected.
    always_comb begin
        w_any_free  = 1'b0;
        w_alloc_idx = '0;
        w_iss_any   = 1'b0;
        w_iss_idx   = '0;
        w_iss_tag   = '0;
        w_iss_late  = 1'b0;
        w_busy      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_state[i] == SLOT_FREE) begin
                w_any_free  = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end else begin
                w_busy = w_busy + CNT_W'(1);
            end
            if ((r_state[i] == SLOT_READY) ||
                ((r_state[i] == SLOT_WAIT) && (r_cnt[i] == DLY_W'(1)))) begin
                w_iss_any  = 1'b1;
                w_iss_idx  = IDX_W'(i);
                w_iss_tag  = r_tag[i];
                w_iss_late = (r_state[i] == SLOT_READY);
            end
        end
    end

    assign req_ready  = ~rst & w_any_free;
    assign w_accept   = req_valid & req_ready & (req_delay != '0);
    assign w_zero_dly = req_valid & req_ready & (req_delay == '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_tag_nxt[i]   = r_tag[i];
            case (r_state[i])
                SLOT_FREE: begin
                    if (w_accept && (w_alloc_idx == IDX_W'(i))) begin
                        w_state_nxt[i] = SLOT_WAIT;
                        w_cnt_nxt[i]   = req_delay;
                        w_tag_nxt[i]   = req_tag;
                    end
                end
                SLOT_WAIT: begin
                    if (r_cnt[i] != '0) begin
                        w_cnt_nxt[i] = r_cnt[i] - DLY_W'(1);
                    end
                    if (r_cnt[i] == DLY_W'(1)) begin
                        w_state_nxt[i] = (w_iss_any && (w_iss_idx == IDX_W'(i))) ?
                                         SLOT_ISSUE : SLOT_READY;
                    end
                end
                SLOT_READY: begin
                    if (w_iss_any && (w_iss_idx == IDX_W'(i))) begin
                        w_state_nxt[i] = SLOT_ISSUE;
                    end
                end
                default: begin
                    w_state_nxt[i] = SLOT_FREE;
                    w_cnt_nxt[i]   = '0;
                    w_tag_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= SLOT_FREE;
                r_cnt[i]   <= '0;
                r_tag[i]   <= '0;
            end
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_late  <= 1'b0;
            r_req_err   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_tag[i]   <= w_tag_nxt[i];
            end
            r_rsp_valid <= w_iss_any;
            r_rsp_tag   <= w_iss_tag;
            r_rsp_late  <= w_iss_late;
            r_req_err   <= w_zero_dly;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_late    = r_rsp_late;
    assign req_err     = r_req_err;
    assign pending_cnt = w_busy;

endmodule

// File: tb/tb_delay_response_scheduler.sv
// Scoreboard bench for delay_response_scheduler: expected responses (tag, late, cycle)
// are queued when requests are driven and matched against the DUT output each cycle.
module tb_delay_response_scheduler;

    localparam int DEPTH = 4;
    localparam int DLY_W = 8;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [DLY_W-1:0] req_delay = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             req_ready;
    logic             req_err;
    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_late;
    logic [CW-1:0]    pending_cnt;

    delay_response_scheduler #(.DEPTH(DEPTH), .DLY_W(DLY_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_delay  (req_delay),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .req_err    (req_err),
        .rsp_valid  (rsp_valid),
        .rsp_tag    (rsp_tag),
        .rsp_late   (rsp_late),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit late;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int t, input bit l, input int c);
        exp_t e;
        e.tag  = t;
        e.late = l;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic drive(input bit v, input int d, input int t);
        req_valid = v;
        req_delay = DLY_W'(d);
        req_tag   = TAG_W'(t);
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && q.size() > 0; i++) @(posedge clk);
        chk("drain", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // cyc at a negedge is the number of the edge that began the current cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("rsp_missing", 0, 1);
            void'(q.pop_front());
        end
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rsp_tag", rsp_tag, e.tag);
                chk("rsp_late", rsp_late, e.late);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end else begin
            chk("rsp_idle", {rsp_tag, rsp_late}, 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int tags [4];
        tags = '{3, 4, 6, 7};

        // reset
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_pending", pending_cnt, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);
        @(negedge clk);
        chk("idle_valid", rsp_valid, 0);
        chk("idle_err", req_err, 0);
        chk("idle_pending", pending_cnt, 0);

        // single request, N=2
        e0 = cyc + 1;
        drive(1, 2, 5);
        push_exp(5, 1'b0, e0 + 2);
        @(negedge clk);
        drive(0, 0, 0);
        chk("single_pend_acc", pending_cnt, 1);
        @(negedge clk);
        chk("single_pend_wait", pending_cnt, 1);
        @(negedge clk);
        chk("single_pend_rsp", pending_cnt, 1);
        @(negedge clk);
        chk("single_pend_free", pending_cnt, 0);
        drain(20);

        // collision: both deadlines on the same edge
        e0 = cyc + 1;
        drive(1, 3, 1);
        push_exp(1, 1'b0, e0 + 3);
        @(negedge clk);
        drive(1, 2, 2);
        push_exp(2, 1'b1, e0 + 4);
        @(negedge clk);
        drive(0, 0, 0);
        drain(20);

        // three-way collision: remaining READY slots stay READY
        e0 = cyc + 1;
        drive(1, 3, 1);
        push_exp(1, 1'b0, e0 + 3);
        @(negedge clk);
        drive(1, 2, 2);
        push_exp(2, 1'b1, e0 + 4);
        @(negedge clk);
        drive(1, 1, 3);
        push_exp(3, 1'b1, e0 + 5);
        @(negedge clk);
        drive(0, 0, 0);
        drain(20);

        // full, ignored requests, refill on the freeing edge
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            drive(1, 10, tags[k]);
        end
        push_exp(3, 1'b0, e0 + 10);
        push_exp(4, 1'b0, e0 + 11);
        push_exp(6, 1'b0, e0 + 12);
        @(negedge clk);
        chk("full_ready", req_ready, 0);
        chk("full_pending", pending_cnt, 4);
        drive(1, 1, 9);
        @(negedge clk);
        chk("full_ignore_pend", pending_cnt, 4);
        chk("full_ignore_err", req_err, 0);
        drive(1, 0, 9);
        @(negedge clk);
        chk("full_zero_no_err", req_err, 0);
        drive(0, 0, 0);
        while (cyc < e0 + 10) @(negedge clk);
        chk("full_ready_in_rsp", req_ready, 0);
        chk("full_pend_in_rsp", pending_cnt, 4);
        @(negedge clk);
        chk("full_ready_after", req_ready, 1);
        chk("full_pend_after", pending_cnt, 3);
        drive(1, 1, 13);
        push_exp(13, 1'b0, e0 + 13);
        push_exp(7, 1'b1, e0 + 14);
        @(negedge clk);
        drive(0, 0, 0);
        chk("acc_and_free_pend", pending_cnt, 3);
        drain(30);

        // zero delay
        drive(1, 0, 8);
        @(negedge clk);
        drive(0, 0, 0);
        chk("zero_err", req_err, 1);
        chk("zero_pend", pending_cnt, 0);
        @(negedge clk);
        chk("zero_err_clear", req_err, 0);
        repeat (3) @(negedge clk);

        // reset mid-flight
        drive(1, 5, 11);
        @(negedge clk);
        drive(0, 0, 0);
        chk("rmf_pend", pending_cnt, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rmf_ready_in_rst", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmf_valid", rsp_valid, 0);
        chk("rmf_tag", rsp_tag, 0);
        chk("rmf_late", rsp_late, 0);
        chk("rmf_err", req_err, 0);
        chk("rmf_pend0", pending_cnt, 0);
        chk("rmf_ready", req_ready, 1);
        repeat (12) @(negedge clk);
        chk("rmf_pend_later", pending_cnt, 0);

        // maximum delay
        e0 = cyc + 1;
        drive(1, 255, 12);
        push_exp(12, 1'b0, e0 + 255);
        @(negedge clk);
        drive(0, 0, 0);
        repeat (150) @(negedge clk);
        chk("max_pend_mid", pending_cnt, 1);
        drain(300);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
